seq_hit_logger: RTL and testbench
=================================

Name: seq_hit_logger

Overview:
- Sits directly downstream of the 1011 Mealy sequence detector. It consumes the detector's registered one-cycle `y` pulse on its `hit` input.
- A free-running bit-position counter timestamps each hit. Timestamps are buffered in a first-word-fall-through FIFO and drained through a valid/ready interface.
- A saturating hit count and a sticky overflow flag are maintained for status readout.

Parameters:
- POS_W, 16, width of the bit-position counter and of each logged timestamp.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 16, width of the saturating hit counter.
- MIN_GAP, 4, minimum spacing in cycles between qualified hits. Used only when SEQ_HIT_GAP_FILTER_EN is defined.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hit  input  1  detection pulse from the detector's `y`; sampled every cycle.
- clr  input  1  synchronous soft clear; same effect as rst on all state.
- pos_data  output  POS_W  head-of-FIFO timestamp; valid only while pos_valid=1.
- pos_valid  output  1  FIFO non-empty.
- pos_ready  input  1  consumer accepts the head entry.
- hit_cnt  output  CNT_W  count of qualified hits, saturating.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky; set when a qualified hit was lost because the FIFO was full.

Behaviour:
- Reset/clear: on rst=1 or clr=1 at a clock edge, the following all become 0:
  - pos counter, FIFO read/write pointers, fifo_level, pos_valid, hit_cnt, ovf, and the gap-filter state.
  - pos_data is don't-care while pos_valid=0.
  - A hit sampled in the same cycle as rst/clr is ignored.
- Position counter:
  - pos increments by 1 every cycle not in reset/clear.
  - Wraps from 2^POS_W-1 to 0 with no flag.
  - The timestamp logged for a hit is the pos value in the cycle hit=1 is sampled, before that edge's increment.
- Qualification:
  - Without the optional feature, every sampled hit=1 is a qualified hit.
- Push:
  - A qualified hit writes its timestamp at the write pointer if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Pop:
  - Occurs when pos_valid=1 and pos_ready=1. The read pointer advances at that edge.
- Data and valid timing:
  - pos_valid = (fifo_level != 0).
  - pos_data always shows the entry at the read pointer, combinationally from storage.
- Latency:
  - A hit at cycle N is visible on pos_data/pos_valid at cycle N+1 if the FIFO was empty.
  - Push into an empty FIFO with pos_ready=1 in the same cycle: no pop (valid was 0); level becomes 1.
- Simultaneous push and pop when 0 < level < DEPTH: level unchanged; both pointers advance.
- Full without a pop:
  - The qualified hit is dropped and ovf goes to 1 at that edge.
  - ovf holds at 1 until rst/clr.
  - The FIFO contents are untouched.
- Hit counter:
  - hit_cnt increments on every qualified hit, whether or not it was stored.
  - It saturates at 2^CNT_W-1 and never wraps.
- Pointers are log2(DEPTH) bits and wrap naturally; fifo_level is tracked separately to distinguish full from empty.
- There is no combinational path from hit to any output. pos_valid and pos_data do not depend combinationally on pos_ready.

Optional Feature:
- Macro: SEQ_HIT_GAP_FILTER_EN.
- Defined:
  - The block keeps a last_pos register and a have_last flag; both are cleared by rst/clr.
  - A sampled hit is qualified only if have_last=0, or if ((pos - last_pos) mod 2^POS_W) >= MIN_GAP.
  - On a qualified hit, last_pos is set to pos and have_last to 1.
  - Unqualified hits are ignored entirely: no push, no count, no ovf.
  - This suppresses overlapping 1011 detections, e.g. "1011011" gives hits 3 cycles apart, so with MIN_GAP=4 the second is dropped.
- Undefined: the filter logic is absent and all hits qualify.

Test Plan:
- Reset state:
  - Stimulus: rst=1 for 2 cycles, then release with hit=0 for 5 cycles.
  - Response: pos_valid=0, fifo_level=0, hit_cnt=0, ovf=0, and the internal pos reaches 5.
- Single hit:
  - Stimulus: after rst release, hit=1 at cycle 7, pos_ready=0.
  - Response: at cycle 8, pos_valid=1, pos_data=7, fifo_level=1, hit_cnt=1. Then pos_ready=1 for 1 cycle → pos_valid=0, level=0.
- Full and overflow (DEPTH=8):
  - Stimulus: 9 hits at pos 10,12,...,26 with pos_ready=0.
  - Response: level=8, hit_cnt=9, ovf=1. Draining yields 10,12,...,24 in order and pos 26 is absent. ovf stays 1 after draining and clears only on clr.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, then hit=1 with pos_ready=1 in the same cycle.
  - Response: level stays 8, ovf unchanged (0), and the new timestamp lands at the tail.
- Saturation and wrap:
  - Stimulus: CNT_W=4, POS_W=4, 20 hits at pos 0,2,...,14,0,2,... with a continuous drain.
  - Response: hit_cnt holds at 15, and pos_data wraps 14→0.
- Gap filter (macro defined, MIN_GAP=4):
  - Stimulus: hits at pos 20, 23, 24, 30.
  - Response: logged 20, 24, 30 (23 is rejected), hit_cnt=3.
  - Same stimulus with the macro undefined: all 4 are logged.

Source files
------------

// File: rtl/seq_hit_logger.sv
// Hit timestamp logger: free-running position counter, FWFT timestamp FIFO, saturating hit count, sticky overflow.
// Optional build macro SEQ_HIT_GAP_FILTER_EN enables the minimum-spacing hit filter.
module seq_hit_logger #(
    parameter int unsigned POS_W   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MIN_GAP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit,
    input  logic                       clr,
    output logic [POS_W-1:0]           pos_data,
    output logic                       pos_valid,
    input  logic                       pos_ready,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_GAP < 1) begin : g_bad_param
            $error("seq_hit_logger: DEPTH must be a power of 2 >= 2 and MIN_GAP >= 1");
        end
    endgenerate

    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             live;
    logic             qual;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign live      = !(rst || clr);
    assign pos_valid = (fifo_level != '0);
    assign pos_data  = mem[rptr];
    assign full      = (fifo_level == LW'(DEPTH));
    assign pop       = pos_valid && pos_ready;
    assign push      = qual && (!full || pop);
    assign drop      = qual && full && !pop;

`ifdef SEQ_HIT_GAP_FILTER_EN
    logic [POS_W-1:0] last_pos;
    logic             have_last;

    // Spacing is measured modulo 2^POS_W so it stays correct across counter wrap.
    assign qual = live && hit &&
                  (!have_last || (POS_W'(pos - last_pos) >= POS_W'(MIN_GAP)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            last_pos  <= '0;
            have_last <= 1'b0;
        end else if (qual) begin
            last_pos  <= pos;
            have_last <= 1'b1;
        end
    end
`else
    assign qual = live && hit;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pos        <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            hit_cnt    <= '0;
            ovf        <= 1'b0;
        end else begin
            pos <= pos + 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop) ovf <= 1'b1;
            if (qual && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
        end
    end

    // Storage carries no reset; contents are only observable while pos_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pos;
    end

endmodule

// File: tb/tb_seq_hit_logger.sv
// Randomized self-checking bench for seq_hit_logger against a queue-based reference model.
// A second small instance (POS_W=4, CNT_W=4) covers counter saturation and timestamp wrap.
module tb_seq_hit_logger;

    logic        clk = 1'b0;
    logic        rst, hit, clr, pos_ready;
    logic [15:0] pos_data;
    logic        pos_valid;
    logic [15:0] hit_cnt;
    logic [3:0]  fifo_level;
    logic        ovf;

    logic        s_hit, s_clr, s_ready;
    logic [3:0]  s_pos_data;
    logic        s_valid;
    logic [3:0]  s_cnt;
    logic [3:0]  s_level;
    logic        s_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    int q[$];
    int m_cnt, m_pos, m_last;
    bit m_ovf, m_have;

    always #5 clk = ~clk;

    seq_hit_logger u_dut (
        .clk(clk), .rst(rst), .hit(hit), .clr(clr),
        .pos_data(pos_data), .pos_valid(pos_valid), .pos_ready(pos_ready),
        .hit_cnt(hit_cnt), .fifo_level(fifo_level), .ovf(ovf)
    );

    seq_hit_logger #(.POS_W(4), .DEPTH(8), .CNT_W(4), .MIN_GAP(1)) u_small (
        .clk(clk), .rst(rst), .hit(s_hit), .clr(s_clr),
        .pos_data(s_pos_data), .pos_valid(s_valid), .pos_ready(s_ready),
        .hit_cnt(s_cnt), .fifo_level(s_level), .ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the FIFO is a queue of timestamps, everything else plain integers.
    task automatic model_step();
        bit qualified, popped;
        if (rst || clr) begin
            q.delete();
            m_cnt = 0; m_pos = 0; m_last = 0; m_ovf = 0; m_have = 0;
        end else begin
            qualified = hit;
`ifdef SEQ_HIT_GAP_FILTER_EN
            qualified = hit && (!m_have || (((m_pos - m_last) % 65536 + 65536) % 65536) >= 4);
            if (qualified) begin
                m_have = 1;
                m_last = m_pos;
            end
`endif
            popped = (q.size() > 0) && pos_ready;
            if (popped) void'(q.pop_front());
            if (qualified) begin
                if (q.size() < 8) q.push_back(m_pos);
                else m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            m_pos = (m_pos + 1) % 65536;
        end
    endtask

    task automatic check_all();
        chk("pos_valid", 32'(pos_valid), 32'(q.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (q.size() != 0) chk("pos_data", 32'(pos_data), 32'(q[0]));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_until(input int p);
        hit = 0;
        while (m_pos != p) cyc();
    endtask

    initial begin
        rst = 1; clr = 0; hit = 0; pos_ready = 0;
        s_hit = 0; s_clr = 0; s_ready = 0;

        // Reset and idle
        cyc(); cyc();
        rst = 0;
        repeat (5) cyc();
        chk("reset_valid", 32'(pos_valid), 32'd0);
        chk("reset_cnt", 32'(hit_cnt), 32'd0);

        // Single hit at pos 7, then one-cycle drain
        idle_until(7);
        hit = 1; cyc(); hit = 0;
        chk("single_data", 32'(pos_data), 32'd7);
        chk("single_level", 32'(fifo_level), 32'd1);
        pos_ready = 1; cyc(); pos_ready = 0;
        chk("single_drained", 32'(pos_valid), 32'd0);

        // Fill past full: 9 hits at 10,12,...,26
        clr = 1; cyc(); clr = 0;
        idle_until(10);
        for (int i = 0; i < 9; i++) begin
            hit = 1; cyc(); hit = 0; cyc();
        end
`ifndef SEQ_HIT_GAP_FILTER_EN
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_cnt", 32'(hit_cnt), 32'd9);
        chk("full_ovf", 32'(ovf), 32'd1);
`endif
        pos_ready = 1;
        for (int i = 0; i < 8; i++) begin
`ifndef SEQ_HIT_GAP_FILTER_EN
            chk("drain_order", 32'(pos_data), 32'(10 + 2 * i));
`endif
            cyc();
        end
        pos_ready = 0;
        chk("ovf_sticky", 32'(ovf), 32'(m_ovf));
        clr = 1; cyc(); clr = 0;
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Full, then simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            hit = 1; cyc(); hit = 0;
            repeat (4) cyc();
        end
        hit = 1; pos_ready = 1; cyc(); hit = 0; pos_ready = 0;
        chk("pushpop_level", 32'(fifo_level), 32'd8);
        chk("pushpop_ovf", 32'(ovf), 32'd0);
        pos_ready = 1;
        repeat (8) cyc();
        pos_ready = 0;

        // Gap-filter pattern: hits at 20, 23, 24, 30
        clr = 1; cyc(); clr = 0;
        idle_until(20); hit = 1; cyc();
        idle_until(23); hit = 1; cyc();
        hit = 1; cyc();
        idle_until(30); hit = 1; cyc(); hit = 0;
`ifdef SEQ_HIT_GAP_FILTER_EN
        chk("gap_cnt", 32'(hit_cnt), 32'd3);
`else
        chk("gap_cnt", 32'(hit_cnt), 32'd4);
`endif
        pos_ready = 1;
        repeat (5) cyc();
        pos_ready = 0;

        // Randomized traffic with varying drain pressure and occasional clears
        for (int i = 0; i < 1500; i++) begin
            hit       = ($urandom_range(0, 2) == 0);
            pos_ready = (i < 500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        hit = 0; pos_ready = 0; clr = 0;

        // Small instance: 20 hits two cycles apart with continuous drain
        s_clr = 1; @(posedge clk); #1; s_clr = 0;
        s_ready = 1;
        for (int k = 0; k < 40; k++) begin
            s_hit = ((k % 2) == 0);
            @(posedge clk); #1;
            if ((k % 2) == 0) begin
                chk("small_valid", 32'(s_valid), 32'd1);
                chk("small_data", 32'(s_pos_data), 32'(k % 16));
            end
        end
        s_hit = 0;
        chk("small_sat", 32'(s_cnt), 32'd15);
        chk("small_ovf", 32'(s_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
